sseg_write_arbiter: RTL and testbench

Round-robin arbiter that shares a bank of seven-segment PIO output slaves between several requesters (processor-side or hardware producers) in the multiprocessor SoC. Each requester asks for "digit d shows value v". The block selects a winner, hex-decodes the value and issues a single Avalon-MM write to that digit's PIO data register. It holds a per-digit shadow copy so unchanged values are acknowledged without bus traffic.

---
 rtl/sseg_write_arbiter_pkg.sv | 24 ++
 rtl/sseg_write_arbiter_if.sv | 29 ++
 rtl/sseg_rr_picker.sv | 28 ++
 rtl/sseg_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_sseg_write_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_write_arbiter_pkg.sv
// Shared types and constants for the seven-segment write arbiter.
// Segment encodings are active-low with bit0 = a through bit6 = g.
package sseg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StWrite,
    StAck
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [v] is the active-low pattern for hex digit v (listed F down to 0).
  localparam logic [15:0][6:0] SEG_DECODE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value, input logic blank);
    return blank ? SEG_BLANK : SEG_DECODE[value];
  endfunction

endpackage

// File: rtl/sseg_write_arbiter_if.sv
// Requester bundle plus Avalon-MM write port of the seven-segment arbiter.
// The master modport is the arbiter; slave is the requesters/bus side.
interface sseg_write_arbiter_if #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_DIGITS = 8
);
  localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_digit;
  logic [N_REQ*4-1:0]  req_value;
  logic [N_REQ-1:0]    req_blank;
  logic [N_REQ-1:0]    req_ack;
  logic [31:0]         avm_address;
  logic                avm_write;
  logic [31:0]         avm_writedata;
  logic                avm_waitrequest;

  modport master (
    input  req_valid, req_digit, req_value, req_blank, avm_waitrequest,
    output req_ack, avm_address, avm_write, avm_writedata
  );

  modport slave (
    output req_valid, req_digit, req_value, req_blank, avm_waitrequest,
    input  req_ack, avm_address, avm_write, avm_writedata
  );

endinterface

// File: rtl/sseg_rr_picker.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo N.
module sseg_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int j;
    j       = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    // Scan from the far end so the last hit is the one closest to the pointer.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      j = (int'(i_ptr) + i) % int'(N);
      if (i_req[j]) begin
        o_valid = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sseg_write_arbiter.sv
// Round-robin arbiter sharing seven-segment PIO slaves; decodes the requested
// nibble, skips writes that match the per-digit shadow, else issues one write.
module sseg_write_arbiter
  import sseg_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned N_DIGITS   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned DIGIT_SPAN = 16
) (
  input logic                 clk,
  input logic                 reset,
  sseg_write_arbiter_if.master bus
);

  localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned IW = $clog2(N_REQ);

  state_e              r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_win;
  logic [DW-1:0]       r_digit;
  logic [3:0]          r_value;
  logic                r_blank;
  logic [6:0]          r_shadow [N_DIGITS];
  logic [N_DIGITS-1:0] r_shadow_valid;
  logic [N_REQ-1:0]    r_ack;
  logic                r_write;
  logic [31:0]         r_address;
  logic [31:0]         r_writedata;

  logic                w_pick_valid;
  logic [IW-1:0]       w_pick_idx;
  logic [DW-1:0]       w_sel_digit;
  logic [3:0]          w_sel_value;
  logic                w_sel_blank;
  logic [6:0]          w_seg;
  logic                w_in_range;
  logic                w_hit;
  logic [31:0]         w_addr;
  logic [IW-1:0]       w_rr_next;
  logic [N_REQ-1:0]    w_ack_vec;

  sseg_rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_sel_digit = '0;
    w_sel_value = '0;
    w_sel_blank = 1'b0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (w_pick_idx == IW'(k)) begin
        w_sel_digit = bus.req_digit[k*DW +: DW];
        w_sel_value = bus.req_value[k*4 +: 4];
        w_sel_blank = bus.req_blank[k];
      end
    end
  end

  always_comb begin
    w_seg      = hex_to_seg(r_value, r_blank);
    w_in_range = (32'(r_digit) < N_DIGITS);
    w_addr     = BASE_ADDR + 32'(DIGIT_SPAN) * 32'(r_digit);
    w_rr_next  = (r_win == IW'(N_REQ - 1)) ? '0 : r_win + IW'(1);
    w_ack_vec  = N_REQ'(1) << r_win;
    w_hit      = 1'b0;
    for (int d = 0; d < int'(N_DIGITS); d++) begin
      if (r_digit == DW'(d) && r_shadow_valid[d] && r_shadow[d] == w_seg) begin
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_rr_ptr       <= '0;
      r_win          <= '0;
      r_digit        <= '0;
      r_value        <= '0;
      r_blank        <= 1'b0;
      r_shadow_valid <= '0;
      r_ack          <= '0;
      r_write        <= 1'b0;
      r_address      <= BASE_ADDR;
      r_writedata    <= '0;
      for (int d = 0; d < int'(N_DIGITS); d++) r_shadow[d] <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pick_valid) begin
            r_win   <= w_pick_idx;
            r_digit <= w_sel_digit;
            r_value <= w_sel_value;
            r_blank <= w_sel_blank;
            r_state <= StGrant;
          end
        end
        StGrant: begin
          // Out-of-range digits and unchanged values complete without bus traffic.
          if (!w_in_range || w_hit) begin
            r_ack   <= w_ack_vec;
            r_state <= StAck;
          end else begin
            r_write     <= 1'b1;
            r_address   <= w_addr;
            r_writedata <= {25'b0, w_seg};
            r_state     <= StWrite;
          end
        end
        StWrite: begin
          if (!bus.avm_waitrequest) begin
            r_write <= 1'b0;
            for (int d = 0; d < int'(N_DIGITS); d++) begin
              if (r_digit == DW'(d)) begin
                r_shadow[d]       <= w_seg;
                r_shadow_valid[d] <= 1'b1;
              end
            end
            r_ack   <= w_ack_vec;
            r_state <= StAck;
          end
        end
        StAck: begin
          r_ack    <= '0;
          r_rr_ptr <= w_rr_next;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ack       = r_ack;
  assign bus.avm_write     = r_write;
  assign bus.avm_address   = r_address;
  assign bus.avm_writedata = r_writedata;

endmodule

// File: tb/tb_sseg_write_arbiter.sv
// Directed bench for sseg_write_arbiter: 4 requesters, 6 digits so that an
// out-of-range digit index is representable.
module tb_sseg_write_arbiter;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sseg_write_arbiter_if #(.N_REQ(4), .N_DIGITS(6)) bus ();

  sseg_write_arbiter #(
    .N_REQ      (4),
    .N_DIGITS   (6),
    .BASE_ADDR  (BASE),
    .DIGIT_SPAN (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Results of the last run_req call.
  int          res_ack_cyc;
  int          res_wr;
  logic [3:0]  res_ack_vec;
  logic [31:0] res_addr;
  logic [31:0] res_data;
  bit          res_stable;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from an IDLE cycle (cycle 0) and observe until its ack.
  task automatic run_req(input int r, input int d, input int v, input bit b, input int stall);
    bus.req_valid[r]         = 1'b1;
    bus.req_digit[r*3 +: 3]  = 3'(d);
    bus.req_value[r*4 +: 4]  = 4'(v);
    bus.req_blank[r]         = b;
    bus.avm_waitrequest      = (stall > 0);
    res_ack_cyc = -1;
    res_wr      = 0;
    res_ack_vec = '0;
    res_addr    = '0;
    res_data    = '0;
    res_stable  = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (bus.avm_write === 1'b1) begin
        if (res_wr > 0 && (bus.avm_address !== res_addr || bus.avm_writedata !== res_data))
          res_stable = 1'b0;
        res_wr++;
        res_addr = bus.avm_address;
        res_data = bus.avm_writedata;
        bus.avm_waitrequest = (res_wr <= stall);
      end
      if (bus.req_ack !== 4'b0000) begin
        res_ack_cyc = cyc;
        res_ack_vec = bus.req_ack;
        break;
      end
    end
    bus.req_valid[r]    = 1'b0;
    bus.avm_waitrequest = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (bus.avm_write !== 1'b0) begin errors++;
      $display("FAIL reset_write: got %b expected 0", bus.avm_write); end
    checks++; if (bus.avm_address !== BASE) begin errors++;
      $display("FAIL reset_addr: got %h expected %h", bus.avm_address, BASE); end
    checks++; if (bus.avm_writedata !== 32'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", bus.avm_writedata); end
    checks++; if (bus.req_ack !== 4'b0000) begin errors++;
      $display("FAIL reset_ack: got %b expected 0000", bus.req_ack); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    run_req(0, 2, 5, 1'b0, 0);
    checks++; if (res_ack_cyc !== 3) begin errors++;
      $display("FAIL single_ack_cycle: got %0d expected 3", res_ack_cyc); end
    checks++; if (res_ack_vec !== 4'b0001) begin errors++;
      $display("FAIL single_ack_vec: got %b expected 0001", res_ack_vec); end
    checks++; if (res_wr !== 1) begin errors++;
      $display("FAIL single_write_cycles: got %0d expected 1", res_wr); end
    checks++; if (res_addr !== 32'h0000_1020) begin errors++;
      $display("FAIL single_addr: got %h expected 00001020", res_addr); end
    checks++; if (res_data !== 32'h12) begin errors++;
      $display("FAIL single_data: got %h expected 00000012", res_data); end
  endtask

  task automatic test_skip_and_blank();
    run_req(0, 2, 5, 1'b0, 0);
    checks++; if (res_ack_cyc !== 2) begin errors++;
      $display("FAIL skip_ack_cycle: got %0d expected 2", res_ack_cyc); end
    checks++; if (res_wr !== 0) begin errors++;
      $display("FAIL skip_write_cycles: got %0d expected 0", res_wr); end
    run_req(3, 2, 5, 1'b1, 0);
    checks++; if (res_wr !== 1 || res_data !== 32'h7F) begin errors++;
      $display("FAIL blank_write: got %0d writes data %h expected 1 writes data 0000007f",
               res_wr, res_data); end
    checks++; if (res_ack_cyc !== 3 || res_ack_vec !== 4'b1000) begin errors++;
      $display("FAIL blank_ack: got cycle %0d vec %b expected cycle 3 vec 1000",
               res_ack_cyc, res_ack_vec); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_vec  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int          exp_cyc  [5] = '{3, 7, 11, 15, 18};
    bit          exp_wr   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_data [5] = '{32'h79, 32'h30, 32'h46, 32'h06, 32'h0};
    logic [3:0]  got_vec  [5];
    int          got_cyc  [5];
    bit          got_wr   [5];
    logic [31:0] got_data [5];
    logic [31:0] got_addr [5];
    int n = 0;
    bit wrote = 1'b0;
    logic [31:0] last_data = '0;
    logic [31:0] last_addr = '0;
    for (int k = 0; k < 5; k++) begin
      got_vec[k] = '0; got_cyc[k] = -1; got_wr[k] = 1'b0; got_data[k] = '0; got_addr[k] = '0;
    end
    bus.req_digit = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.req_value = {4'hE, 4'hC, 4'h3, 4'h1};
    bus.req_blank = 4'b0000;
    bus.req_valid = 4'b1111;
    for (int cyc = 1; cyc <= 60 && n < 5; cyc++) begin
      step();
      if (bus.avm_write === 1'b1) begin
        wrote = 1'b1; last_data = bus.avm_writedata; last_addr = bus.avm_address;
      end
      if (bus.req_ack !== 4'b0000) begin
        got_vec[n] = bus.req_ack; got_cyc[n] = cyc; got_wr[n] = wrote;
        got_data[n] = last_data; got_addr[n] = last_addr;
        wrote = 1'b0;
        n++;
      end
    end
    bus.req_valid = 4'b0000;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++; if (got_vec[k] !== exp_vec[k] || got_cyc[k] !== exp_cyc[k]) begin errors++;
        $display("FAIL rr_grant%0d: got vec %b cycle %0d expected vec %b cycle %0d",
                 k, got_vec[k], got_cyc[k], exp_vec[k], exp_cyc[k]); end
      checks++; if (got_wr[k] !== exp_wr[k]) begin errors++;
        $display("FAIL rr_wrote%0d: got %b expected %b", k, got_wr[k], exp_wr[k]); end
      if (exp_wr[k]) begin
        checks++;
        if (got_data[k] !== exp_data[k] || got_addr[k] !== BASE + 32'(16 * k)) begin errors++;
          $display("FAIL rr_bus%0d: got addr %h data %h expected addr %h data %h", k,
                   got_addr[k], got_data[k], BASE + 32'(16 * k), exp_data[k]); end
      end
    end
  endtask

  task automatic test_stall();
    run_req(3, 4, 7, 1'b0, 5);
    checks++; if (res_wr !== 6) begin errors++;
      $display("FAIL stall_write_cycles: got %0d expected 6", res_wr); end
    checks++; if (res_stable !== 1'b1) begin errors++;
      $display("FAIL stall_stable: got %b expected 1", res_stable); end
    checks++; if (res_addr !== 32'h0000_1040 || res_data !== 32'h78) begin errors++;
      $display("FAIL stall_bus: got addr %h data %h expected 00001040 00000078",
               res_addr, res_data); end
    checks++; if (res_ack_cyc !== 8 || res_ack_vec !== 4'b1000) begin errors++;
      $display("FAIL stall_ack: got cycle %0d vec %b expected cycle 8 vec 1000",
               res_ack_cyc, res_ack_vec); end
    run_req(3, 4, 7, 1'b0, 0);
    checks++; if (res_wr !== 0 || res_ack_cyc !== 2) begin errors++;
      $display("FAIL stall_shadow: got %0d writes ack cycle %0d expected 0 writes cycle 2",
               res_wr, res_ack_cyc); end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    bus.req_digit[1*3 +: 3] = 3'd1;
    bus.req_value[1*4 +: 4] = 4'h9;
    bus.req_blank[1]        = 1'b0;
    bus.avm_waitrequest     = 1'b1;
    bus.req_valid[1]        = 1'b1;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      step();
      if (bus.avm_write === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++;
      $display("FAIL midrst_write_seen: got %b expected 1", seen); end
    reset = 1'b1;
    step();
    checks++; if (bus.avm_write !== 1'b0 || bus.req_ack !== 4'b0000) begin errors++;
      $display("FAIL midrst_drop: got write %b ack %b expected 0 0000",
               bus.avm_write, bus.req_ack); end
    bus.req_valid[1]    = 1'b0;
    bus.avm_waitrequest = 1'b0;
    step();
    reset = 1'b0;
    step();
    run_req(1, 1, 9, 1'b0, 0);
    checks++; if (res_wr !== 1 || res_data !== 32'h10 || res_ack_cyc !== 3) begin errors++;
      $display("FAIL midrst_reissue: got %0d writes data %h cycle %0d expected 1 00000010 3",
               res_wr, res_data, res_ack_cyc); end
    // Digit 0 held 0x79 before the reset; the shadow must have been invalidated.
    run_req(0, 0, 1, 1'b0, 0);
    checks++; if (res_wr !== 1 || res_data !== 32'h79) begin errors++;
      $display("FAIL midrst_shadow_clear: got %0d writes data %h expected 1 00000079",
               res_wr, res_data); end
  endtask

  task automatic test_out_of_range();
    run_req(2, 6, 3, 1'b0, 0);
    checks++; if (res_wr !== 0) begin errors++;
      $display("FAIL oor_write: got %0d writes expected 0", res_wr); end
    checks++; if (res_ack_cyc !== 2 || res_ack_vec !== 4'b0100) begin errors++;
      $display("FAIL oor_ack: got cycle %0d vec %b expected cycle 2 vec 0100",
               res_ack_cyc, res_ack_vec); end
    run_req(2, 3, 10, 1'b0, 0);
    checks++; if (res_wr !== 1 || res_addr !== 32'h0000_1030 || res_data !== 32'h08) begin
      errors++;
      $display("FAIL oor_followup: got %0d writes addr %h data %h expected 1 00001030 00000008",
               res_wr, res_addr, res_data); end
    checks++; if (res_ack_cyc !== 3 || res_ack_vec !== 4'b0100) begin errors++;
      $display("FAIL oor_followup_ack: got cycle %0d vec %b expected cycle 3 vec 0100",
               res_ack_cyc, res_ack_vec); end
  endtask

  initial begin
    bus.req_valid       = '0;
    bus.req_digit       = '0;
    bus.req_value       = '0;
    bus.req_blank       = '0;
    bus.avm_waitrequest = 1'b0;
    test_reset();
    test_single_write();
    test_skip_and_blank();
    test_round_robin();
    test_stall();
    test_reset_mid_write();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
